// File: rtl/vga_scan_engine.sv
// VGA raster engine: sync/blank timing, tiled framebuffer read addressing with latency-aligned colour,
// and a frame-synchronous double-buffer swap handshake.
module vga_scan_engine #(
  parameter int          H_SYNC     = 128,
  parameter int          H_BP       = 88,
  parameter int          H_ACTIVE   = 800,
  parameter int          H_FP       = 40,
  parameter int          V_SYNC     = 4,
  parameter int          V_BP       = 23,
  parameter int          V_ACTIVE   = 600,
  parameter int          V_FP       = 1,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter int          TILE_LOG2  = 4,
  parameter int          TILES_X    = 40,
  parameter int          RD_LATENCY = 1,
  parameter logic [11:0] BORDER_RGB = 12'h00F,
  localparam int         TILE_W     = $clog2((TILES_X * IMG_H) >> TILE_LOG2),
  localparam int         PX_W       = 2 * TILE_LOG2
) (
  input  logic              clk_vga,
  input  logic              reset_n,
  input  logic              i_swap_req,
  input  logic [11:0]       i_pix_rgb,
  output logic              o_rd_en,
  output logic [TILE_W-1:0] o_rd_tile,
  output logic [PX_W-1:0]   o_rd_px,
  output logic              o_buf_sel,
  output logic              o_swap_ack,
  output logic [3:0]        o_red,
  output logic [3:0]        o_green,
  output logic [3:0]        o_blue,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_vblank,
  output logic              o_frame_start
);

  localparam int H_T  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_T  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW   = $clog2(H_T);
  localparam int VW   = $clog2(V_T);
  localparam int H_S  = H_SYNC + H_BP;
  localparam int V_S  = V_SYNC + V_BP;
  // Read decisions are made one state ahead so o_rd_en itself is a register.
  localparam int RD_S = H_S - RD_LATENCY - 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_T - 1);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_S  = HW'(H_S);
  localparam logic [HW-1:0] RD_X0    = HW'(RD_S);
  localparam logic [HW-1:0] RD_IMG_E = HW'(RD_S + IMG_W - 1);
  localparam logic [HW-1:0] RD_ACT_E = HW'(RD_S + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_T - 1);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_S  = VW'(V_S);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_S + V_ACTIVE - 1);
  localparam logic [VW-1:0] V_IMG_E  = VW'(V_S + IMG_H - 1);

  if ((H_SYNC + H_BP <= RD_LATENCY) || (RD_LATENCY < 1) || (RD_LATENCY > 8)) begin : g_cfg_err
    $error("vga_scan_engine: RD_LATENCY must be 1..8 and below H_SYNC+H_BP");
  end

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} swap_state_t;

  logic [HW-1:0]       hcnt, rd_x;
  logic [VW-1:0]       vcnt, rd_y;
  logic                v_act, v_img, img_la, act_la, swap_pt, swap_go;
  logic [TILE_W-1:0]   tile_nxt;
  logic [PX_W-1:0]     px_nxt;
  logic [RD_LATENCY:0] img_p, act_p;
  swap_state_t         sw_state, sw_nxt;

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign v_act    = (vcnt >= V_ACT_S) && (vcnt <= V_ACT_E);
  assign v_img    = (vcnt >= V_ACT_S) && (vcnt <= V_IMG_E);
  assign img_la   = v_img && (hcnt >= RD_X0) && (hcnt <= RD_IMG_E);
  assign act_la   = v_act && (hcnt >= RD_X0) && (hcnt <= RD_ACT_E);
  assign rd_x     = hcnt - RD_X0;
  assign rd_y     = vcnt - V_ACT_S;
  assign tile_nxt = TILE_W'(rd_y >> TILE_LOG2) * TILE_W'(TILES_X) + TILE_W'(rd_x >> TILE_LOG2);
  assign px_nxt   = {rd_y[TILE_LOG2-1:0], rd_x[TILE_LOG2-1:0]};
  assign swap_pt  = (hcnt == H_LAST) && (vcnt == V_ACT_E);

  // Stage 0 is the read strobe; stage RD_LATENCY lines up with the returning pixel.
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      img_p     <= '0;
      act_p     <= '0;
      o_rd_tile <= '0;
      o_rd_px   <= '0;
    end else begin
      img_p <= {img_p[RD_LATENCY-1:0], img_la};
      act_p <= {act_p[RD_LATENCY-1:0], act_la};
      if (img_la) begin
        o_rd_tile <= tile_nxt;
        o_rd_px   <= px_nxt;
      end
    end
  end

  assign o_rd_en = img_p[0];

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      {o_red, o_green, o_blue} <= '0;
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_vblank      <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      if (act_p[RD_LATENCY])
        {o_red, o_green, o_blue} <= img_p[RD_LATENCY] ? i_pix_rgb : BORDER_RGB;
      else
        {o_red, o_green, o_blue} <= '0;
      o_hs          <= (hcnt < H_SYNC_E) ? HS_POL : ~HS_POL;
      o_vs          <= (vcnt < V_SYNC_E) ? VS_POL : ~VS_POL;
      o_vblank      <= ~v_act;
      o_frame_start <= (hcnt == H_ACT_S) && (vcnt == V_ACT_S);
    end
  end

  // Swapping only at the end of the last active line keeps bank changes inside blanking.
  always_comb begin
    sw_nxt  = sw_state;
    swap_go = 1'b0;
    case (sw_state)
      IDLE: if (i_swap_req) sw_nxt = PEND;
      PEND: if (swap_pt) begin
        swap_go = 1'b1;
        sw_nxt  = IDLE;
      end
      default: sw_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      sw_state   <= IDLE;
      o_swap_ack <= 1'b0;
      o_buf_sel  <= 1'b0;
    end else begin
      sw_state   <= sw_nxt;
      o_swap_ack <= swap_go;
      if (swap_go) o_buf_sel <= ~o_buf_sel;
    end
  end

endmodule
